// File: rtl/cpu_bus_write_responder_if.sv
// ============================================================================
// Module      : cpu_bus_write_responder_if
// Description : CPU external-bus write-side pins (chip select, WE, address, data).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_bus_write_responder_if;
  logic        cn;
  logic        we0_n;
  logic [16:0] addr;
  logic [15:0] data;

  modport master (output cn, we0_n, addr, data);
  modport slave  (input  cn, we0_n, addr, data);
endinterface

`default_nettype wire

// File: rtl/cpu_bus_write_responder.sv
// ============================================================================
// Module      : cpu_bus_write_responder
// Description : Qualifies CPU bus write cycles and issues one-cycle BRAM write
//               strobes with segment/page-expanded addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_write_responder #(
  parameter int          MIN_WE_CYCLES           = 2,
  parameter int          DROP_CNT_W              = 8,
  parameter logic [1:0]  BRAM_SELECT_CONTROLLER  = 2'd0,
  parameter logic [1:0]  BRAM_SELECT_MOD         = 2'd1,
  parameter logic [1:0]  BRAM_SELECT_STM         = 2'd2,
  parameter logic [1:0]  BRAM_SELECT_PWE_TABLE   = 2'd3,
  parameter logic [13:0] ADDR_MOD_MEM_WR_SEGMENT = 14'h0020,
  parameter logic [13:0] ADDR_STM_MEM_WR_SEGMENT = 14'h0021,
  parameter logic [13:0] ADDR_STM_MEM_WR_PAGE    = 14'h0022
) (
  input  logic                      clk,
  input  logic                      rst,
  cpu_bus_write_responder_if.slave  bus,
  output logic                      cnt_we,
  output logic [13:0]               cnt_addr,
  output logic                      mod_we,
  output logic [14:0]               mod_addr,
  output logic                      stm_we,
  output logic [18:0]               stm_addr,
  output logic                      pwe_we,
  output logic [6:0]                pwe_addr,
  output logic [15:0]               data_out,
  output logic                      mod_wr_segment,
  output logic                      stm_wr_segment,
  output logic [3:0]                stm_wr_page,
  output logic [DROP_CNT_W-1:0]     drop_cnt
);

  localparam int                 CNT_W    = $clog2(MIN_WE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   C_WE_MIN = CNT_W'(MIN_WE_CYCLES);
  localparam logic [CNT_W-1:0]   C_WE_ONE = CNT_W'(1);
  localparam logic [DROP_CNT_W-1:0] C_DROP_MAX = {DROP_CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECTED = 3'd1,
    S_WE_LOW   = 3'd2,
    S_COMMIT   = 3'd3,
    S_DROP     = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_we_cnt;
  logic [CNT_W-1:0] w_we_cnt_nxt;
  logic             w_latch;

  logic             r_cn;
  logic             r_we;
  logic [16:1]      r_addr_in;
  logic [15:0]      r_data_in;
  logic [16:1]      r_addr;
  logic [15:0]      r_data;

  // Byte lane bit is meaningless for 16-bit writes.
  logic             w_unused_addr0;
  assign w_unused_addr0 = bus.addr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cn      <= 1'b1;
      r_we      <= 1'b1;
      r_addr_in <= '0;
      r_data_in <= '0;
    end else begin
      r_cn      <= bus.cn;
      r_we      <= bus.we0_n;
      r_addr_in <= bus.addr[16:1];
      r_data_in <= bus.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_we_cnt <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_we_cnt <= w_we_cnt_nxt;
      if (w_latch) begin
        r_addr <= r_addr_in;
        r_data <= r_data_in;
      end
    end
  end

  // The first sampled-low cycle is counted on entry to WE_LOW, and a new
  // WE-low seen during COMMIT/DROP goes straight to WE_LOW so no sample is lost.
  always_comb begin
    w_state_nxt  = r_state;
    w_we_cnt_nxt = r_we_cnt;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_cn) w_state_nxt = S_SELECTED;
      end
      S_SELECTED: begin
        if (r_cn) begin
          w_state_nxt = S_IDLE;
        end else if (!r_we) begin
          w_state_nxt  = S_WE_LOW;
          w_we_cnt_nxt = C_WE_ONE;
          w_latch      = 1'b1;
        end
      end
      S_WE_LOW: begin
        if (r_we) begin
          w_state_nxt  = (r_we_cnt >= C_WE_MIN) ? S_COMMIT : S_DROP;
          w_we_cnt_nxt = '0;
        end else if (r_cn) begin
          w_state_nxt  = S_DROP;
          w_we_cnt_nxt = '0;
        end else begin
          w_latch = 1'b1;
          if (r_we_cnt < C_WE_MIN) w_we_cnt_nxt = r_we_cnt + C_WE_ONE;
        end
      end
      S_COMMIT, S_DROP: begin
        if (r_cn) begin
          w_state_nxt = S_IDLE;
        end else if (!r_we) begin
          w_state_nxt  = S_WE_LOW;
          w_we_cnt_nxt = C_WE_ONE;
          w_latch      = 1'b1;
        end else begin
          w_state_nxt = S_SELECTED;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_we_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_we         <= 1'b0;
      cnt_addr       <= '0;
      mod_we         <= 1'b0;
      mod_addr       <= '0;
      stm_we         <= 1'b0;
      stm_addr       <= '0;
      pwe_we         <= 1'b0;
      pwe_addr       <= '0;
      data_out       <= '0;
      mod_wr_segment <= 1'b0;
      stm_wr_segment <= 1'b0;
      stm_wr_page    <= '0;
      drop_cnt       <= '0;
    end else begin
      cnt_we <= 1'b0;
      mod_we <= 1'b0;
      stm_we <= 1'b0;
      pwe_we <= 1'b0;
      if (r_state == S_COMMIT) begin
        data_out <= r_data;
        if (r_addr[16:15] == BRAM_SELECT_CONTROLLER) begin
          cnt_we   <= 1'b1;
          cnt_addr <= r_addr[14:1];
          // Segment/page registers take effect from the next commit onward.
          if (r_addr[14:1] == ADDR_MOD_MEM_WR_SEGMENT) mod_wr_segment <= r_data[0];
          if (r_addr[14:1] == ADDR_STM_MEM_WR_SEGMENT) stm_wr_segment <= r_data[0];
          if (r_addr[14:1] == ADDR_STM_MEM_WR_PAGE)    stm_wr_page    <= r_data[3:0];
        end else if (r_addr[16:15] == BRAM_SELECT_MOD) begin
          mod_we   <= 1'b1;
          mod_addr <= {mod_wr_segment, r_addr[14:1]};
        end else if (r_addr[16:15] == BRAM_SELECT_STM) begin
          stm_we   <= 1'b1;
          stm_addr <= {stm_wr_segment, stm_wr_page, r_addr[14:1]};
        end else if (r_addr[16:15] == BRAM_SELECT_PWE_TABLE) begin
          pwe_we   <= 1'b1;
          pwe_addr <= r_addr[7:1];
        end
      end
      if (r_state == S_DROP && drop_cnt != C_DROP_MAX) begin
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_write_responder.sv
// ============================================================================
// Module      : tb_cpu_bus_write_responder
// Description : Directed bench with a transaction-level expected-strobe model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_bus_write_responder;

  localparam int          MIN_WE    = 2;
  localparam int          DROP_W    = 8;
  localparam logic [1:0]  SEL_CNT   = 2'd0;
  localparam logic [1:0]  SEL_MOD   = 2'd1;
  localparam logic [1:0]  SEL_STM   = 2'd2;
  localparam logic [1:0]  SEL_PWE   = 2'd3;
  localparam logic [13:0] A_MOD_SEG = 14'h0020;
  localparam logic [13:0] A_STM_SEG = 14'h0021;
  localparam logic [13:0] A_PAGE    = 14'h0022;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cnt_we, mod_we, stm_we, pwe_we;
  logic [13:0]       cnt_addr;
  logic [14:0]       mod_addr;
  logic [18:0]       stm_addr;
  logic [6:0]        pwe_addr;
  logic [15:0]       data_out;
  logic              mod_wr_segment, stm_wr_segment;
  logic [3:0]        stm_wr_page;
  logic [DROP_W-1:0] drop_cnt;

  cpu_bus_write_responder_if bus ();

  cpu_bus_write_responder #(
    .MIN_WE_CYCLES          (MIN_WE),
    .DROP_CNT_W             (DROP_W),
    .BRAM_SELECT_CONTROLLER (SEL_CNT),
    .BRAM_SELECT_MOD        (SEL_MOD),
    .BRAM_SELECT_STM        (SEL_STM),
    .BRAM_SELECT_PWE_TABLE  (SEL_PWE),
    .ADDR_MOD_MEM_WR_SEGMENT(A_MOD_SEG),
    .ADDR_STM_MEM_WR_SEGMENT(A_STM_SEG),
    .ADDR_STM_MEM_WR_PAGE   (A_PAGE)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .cnt_we         (cnt_we),
    .cnt_addr       (cnt_addr),
    .mod_we         (mod_we),
    .mod_addr       (mod_addr),
    .stm_we         (stm_we),
    .stm_addr       (stm_addr),
    .pwe_we         (pwe_we),
    .pwe_addr       (pwe_addr),
    .data_out       (data_out),
    .mod_wr_segment (mod_wr_segment),
    .stm_wr_segment (stm_wr_segment),
    .stm_wr_page    (stm_wr_page),
    .drop_cnt       (drop_cnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // One entry per bus cycle: the clock count at which its effect must be visible.
  typedef struct {
    int          cyc;
    bit          drop;
    logic [16:0] a;
    logic [15:0] d;
  } ev_t;
  ev_t q[$];

  logic       m_mseg = 1'b0, m_sseg = 1'b0;
  logic [3:0] m_page = 4'd0;
  int         m_drop = 0;

  logic [13:0] seen_cnt_addr = '0;
  logic [14:0] seen_mod_addr = '0;
  logic [18:0] seen_stm_addr = '0;
  logic [6:0]  seen_pwe_addr = '0;
  logic [15:0] seen_data     = '0;
  int          n_stm_seen    = 0;
  bit          chk_en        = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] ba(input logic [1:0] s, input logic [13:0] w);
    return {s, w, 1'b0};
  endfunction

  ev_t         c_ev;
  logic        e_cnt, e_mod, e_stm, e_pwe, e_strobe;
  logic [31:0] e_addr;
  logic [15:0] e_data;
  logic [13:0] c_wd;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      e_cnt = 1'b0; e_mod = 1'b0; e_stm = 1'b0; e_pwe = 1'b0; e_strobe = 1'b0;
      e_addr = '0; e_data = '0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check("event_overdue", 32'(cyc), 32'(q[0].cyc));
        c_ev = q.pop_front();
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        c_ev = q.pop_front();
        if (c_ev.drop) begin
          if (m_drop < (1 << DROP_W) - 1) m_drop++;
        end else begin
          c_wd     = c_ev.a[14:1];
          e_strobe = 1'b1;
          e_data   = c_ev.d;
          case (c_ev.a[16:15])
            SEL_CNT: begin
              e_cnt  = 1'b1;
              e_addr = 32'(c_wd);
              if (c_wd == A_MOD_SEG) m_mseg = c_ev.d[0];
              if (c_wd == A_STM_SEG) m_sseg = c_ev.d[0];
              if (c_wd == A_PAGE)    m_page = c_ev.d[3:0];
            end
            SEL_MOD: begin e_mod = 1'b1; e_addr = 32'({m_mseg, c_wd}); end
            SEL_STM: begin e_stm = 1'b1; e_addr = 32'({m_sseg, m_page, c_wd}); end
            default: begin e_pwe = 1'b1; e_addr = 32'(c_wd) % 32'd128; end
          endcase
        end
      end
      check("cnt_we", 32'(cnt_we), 32'(e_cnt));
      check("mod_we", 32'(mod_we), 32'(e_mod));
      check("stm_we", 32'(stm_we), 32'(e_stm));
      check("pwe_we", 32'(pwe_we), 32'(e_pwe));
      if (e_cnt) check("cnt_addr", 32'(cnt_addr), e_addr);
      if (e_mod) check("mod_addr", 32'(mod_addr), e_addr);
      if (e_stm) check("stm_addr", 32'(stm_addr), e_addr);
      if (e_pwe) check("pwe_addr", 32'(pwe_addr), e_addr);
      if (e_strobe) check("data_out", 32'(data_out), 32'(e_data));
      check("mod_wr_segment", 32'(mod_wr_segment), 32'(m_mseg));
      check("stm_wr_segment", 32'(stm_wr_segment), 32'(m_sseg));
      check("stm_wr_page", 32'(stm_wr_page), 32'(m_page));
      check("drop_cnt", 32'(drop_cnt), m_drop);
      if (cnt_we) begin seen_cnt_addr = cnt_addr; seen_data = data_out; end
      if (mod_we) begin seen_mod_addr = mod_addr; seen_data = data_out; end
      if (stm_we) begin seen_stm_addr = stm_addr; seen_data = data_out; n_stm_seen++; end
      if (pwe_we) begin seen_pwe_addr = pwe_addr; seen_data = data_out; end
    end
  end

  // Called at a negedge; returns at a negedge. WE is low for nlow sampled edges.
  task automatic wr(input logic [16:0] a, input logic [15:0] d, input int nlow,
                    input bit cn_lost, input bit keep_cn, input int gap);
    ev_t e;
    if (bus.cn) begin
      bus.cn = 1'b0;
      @(negedge clk);
    end
    bus.addr  = a;
    bus.data  = d;
    bus.we0_n = 1'b0;
    repeat (nlow) @(negedge clk);
    e.cyc = cyc + 3;
    e.a   = a;
    e.d   = d;
    if (cn_lost) begin
      bus.cn = 1'b1;
      e.drop = 1'b1;
      q.push_back(e);
      @(negedge clk);
      bus.we0_n = 1'b1;
    end else begin
      bus.we0_n = 1'b1;
      e.drop    = (nlow < MIN_WE);
      q.push_back(e);
      if (!keep_cn) bus.cn = 1'b1;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int stm_base;
    bus.cn = 1'b1; bus.we0_n = 1'b1; bus.addr = '0; bus.data = '0;
    repeat (3) @(negedge clk);
    check("rst_cnt_we", 32'(cnt_we), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_stm_addr", 32'(stm_addr), 32'd0);
    check("rst_page", 32'(stm_wr_page), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    wr(ba(SEL_CNT, 14'h0005), 16'hBEEF, 2, 1'b0, 1'b0, 2);
    drain();
    check("lit_cnt_addr", 32'(seen_cnt_addr), 32'h005);
    check("lit_cnt_data", 32'(seen_data), 32'hBEEF);

    wr(ba(SEL_CNT, A_PAGE), 16'h0003, 2, 1'b0, 1'b0, 2);
    drain();
    check("lit_page_cnt_addr", 32'(seen_cnt_addr), 32'h022);
    wr(ba(SEL_STM, 14'h0010), 16'h1234, 2, 1'b0, 1'b0, 2);
    drain();
    check("lit_stm_addr", 32'(seen_stm_addr), 32'h0C010);
    check("lit_stm_data", 32'(seen_data), 32'h1234);

    wr(ba(SEL_CNT, A_MOD_SEG), 16'h0001, 3, 1'b0, 1'b0, 2);
    wr(ba(SEL_MOD, 14'h0007), 16'hAAAA, 2, 1'b0, 1'b0, 2);
    drain();
    check("lit_mod_addr", 32'(seen_mod_addr), 32'h4007);
    wr(ba(SEL_PWE, 14'h0085), 16'h5555, 2, 1'b0, 1'b0, 2);
    drain();
    check("lit_pwe_addr", 32'(seen_pwe_addr), 32'h05);

    wr(ba(SEL_STM, 14'h0001), 16'h0BAD, 1, 1'b0, 1'b0, 2);
    drain();
    check("lit_drop_one", 32'(drop_cnt), 32'd1);
    wr(ba(SEL_MOD, 14'h0002), 16'h0BAD, 3, 1'b1, 1'b0, 2);
    drain();
    check("lit_drop_cn_lost", 32'(drop_cnt), 32'd2);

    wr(ba(SEL_CNT, A_STM_SEG), 16'h0001, 2, 1'b0, 1'b0, 2);
    wr(ba(SEL_CNT, A_PAGE), 16'h000F, 2, 1'b0, 1'b0, 2);
    drain();
    stm_base = n_stm_seen;
    for (int i = 0; i < 16; i++) begin
      wr(ba(SEL_STM, 14'(i * 3 + 1)), 16'h1000 + 16'(i), 2, 1'b0, (i != 15), (i % 2 == 1) ? 1 : 2);
    end
    drain();
    check("lit_b2b_count", 32'(n_stm_seen - stm_base), 32'd16);
    check("lit_b2b_last_addr", 32'(seen_stm_addr), 32'h7C02E);
    check("lit_b2b_last_data", 32'(seen_data), 32'h100F);

    for (int i = 0; i < 300; i++) begin
      wr(ba(SEL_CNT, 14'h0001), 16'(i), 1, (i % 3 == 0), 1'b0, 2);
    end
    drain();
    check("lit_drop_saturated", 32'(drop_cnt), 32'd255);

    bus.cn = 1'b0;
    @(negedge clk);
    bus.addr  = ba(SEL_STM, 14'h0003);
    bus.data  = 16'hDEAD;
    bus.we0_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("mid_rst_stm_we", 32'(stm_we), 32'd0);
    check("mid_rst_data_out", 32'(data_out), 32'd0);
    check("mid_rst_mod_seg", 32'(mod_wr_segment), 32'd0);
    check("mid_rst_stm_seg", 32'(stm_wr_segment), 32'd0);
    check("mid_rst_page", 32'(stm_wr_page), 32'd0);
    check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("mid_rst_stm_addr", 32'(stm_addr), 32'd0);
    q.delete();
    m_mseg = 1'b0; m_sseg = 1'b0; m_page = 4'd0; m_drop = 0;
    bus.we0_n = 1'b1;
    bus.cn    = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    repeat (6) @(negedge clk);
    wr(ba(SEL_STM, 14'h0004), 16'h4321, 2, 1'b0, 1'b0, 2);
    drain();
    check("lit_post_rst_stm_addr", 32'(seen_stm_addr), 32'h00004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
